// File: rtl/baud_pkg.sv
// baud_pkg: shared rate table, defaults and increment calculation for baud_tick_gen
package baud_pkg;
  localparam int CLK_HZ_D = 50_000_000;
  localparam int OVERSAMPLE_D = 16;
  localparam int NUM_RATES_D = 4;
  localparam int ACC_W_D = 24;
  localparam int RATE [NUM_RATES_D] = '{9600, 19200, 57600, 115200};
  localparam int SEL_W = $clog2(NUM_RATES_D);
  localparam int OS_HALF = OVERSAMPLE_D / 2;
  function automatic longint inc_calc(longint rate, longint os, longint clk_hz, int acc_w);
    return (rate * os * (longint'(1) << acc_w) + clk_hz / 2) / clk_hz;
  endfunction
endpackage

// File: rtl/baud_tick_gen_phase_acc.sv
// baud_tick_gen_phase_acc: fractional phase accumulator; carry marks each oversample instant
module baud_tick_gen_phase_acc #(
  parameter int ACC_W = 24
) (
  input  logic             clk_50,
  input  logic             RESET,
  input  logic             restart,
  input  logic             enable,
  input  logic [ACC_W-1:0] inc,
  output logic             carry
);
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + {1'b0, inc};
  assign carry = sum[ACC_W] & enable & ~restart;
  // restart zeroes the phase and drops any carry; disabled cycles hold it
  always_ff @(posedge clk_50 or posedge RESET)
    if (RESET) acc <= '0;
    else if (restart) acc <= '0;
    else if (enable) acc <= sum[ACC_W-1:0];
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: multi-rate oversample/mid-bit/bit-boundary strobe generator
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_D,
  parameter int OVERSAMPLE = OVERSAMPLE_D,
  parameter int NUM_RATES  = NUM_RATES_D,
  parameter int ACC_W      = ACC_W_D
) (
  input  logic                         clk_50,
  input  logic                         RESET,
  input  logic                         ENABLE,
  input  logic [$clog2(NUM_RATES)-1:0] RATE_SEL,
  input  logic                         RESYNC,
  output logic                         OS_TICK,
  output logic                         MID_TICK,
  output logic                         BAUD_TICK,
  output logic [$clog2(NUM_RATES)-1:0] RATE_IDX
);
  localparam int sel_w = $clog2(NUM_RATES);
  localparam int os_w = $clog2(OVERSAMPLE);
  localparam int os_half = OVERSAMPLE / 2;
  if ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0 || OVERSAMPLE < 4 || OVERSAMPLE > 64) begin : g_bad_os
    $error("OVERSAMPLE must be a power of two in 4..64");
  end
  logic [ACC_W-1:0] inc_tab [NUM_RATES];
  for (genvar g = 0; g < NUM_RATES; g++) begin : g_inc
    localparam longint v = inc_calc(RATE[g], OVERSAMPLE, CLK_HZ, ACC_W);
    if (v == 0 || v >= (longint'(1) << ACC_W)) begin : g_bad_inc
      $error("rate increment out of range");
    end
    assign inc_tab[g] = ACC_W'(v);
  end
  logic [sel_w-1:0] rate_q, sel_c;
  logic [os_w-1:0] os_cnt, os_nxt;
  logic carry, restart;
  assign sel_c = RATE_SEL > sel_w'(NUM_RATES - 1) ? sel_w'(NUM_RATES - 1) : RATE_SEL;
  assign restart = RESYNC | (sel_c != rate_q);
  assign os_nxt = os_cnt + 1'b1;
  assign RATE_IDX = rate_q;
  baud_tick_gen_phase_acc #(.ACC_W(ACC_W)) u_phase_acc (
    .clk_50 (clk_50),
    .RESET  (RESET),
    .restart(restart),
    .enable (ENABLE),
    .inc    (inc_tab[rate_q]),
    .carry  (carry)
  );
  // rate register, oversample counter and strobes; carry is already gated by restart/enable
  always_ff @(posedge clk_50 or posedge RESET)
    if (RESET) begin
      rate_q <= '0;
      os_cnt <= '0;
      OS_TICK <= 1'b0;
      MID_TICK <= 1'b0;
      BAUD_TICK <= 1'b0;
    end else begin
      rate_q <= sel_c;
      OS_TICK <= carry;
      MID_TICK <= carry & (os_nxt == os_w'(os_half));
      BAUD_TICK <= carry & (os_nxt == '0);
      os_cnt <= restart ? '0 : carry ? os_nxt : os_cnt;
    end
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: scoreboard bench for baud_tick_gen with directed timing checks
module tb_baud_tick_gen;
  logic clk_50 = 1'b0;
  logic RESET, ENABLE, RESYNC;
  logic [1:0] RATE_SEL;
  logic OS_TICK, MID_TICK, BAUD_TICK;
  logic [1:0] RATE_IDX;
  always #10 clk_50 = ~clk_50;
  baud_tick_gen dut (
    .clk_50   (clk_50),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .RATE_SEL (RATE_SEL),
    .RESYNC   (RESYNC),
    .OS_TICK  (OS_TICK),
    .MID_TICK (MID_TICK),
    .BAUD_TICK(BAUD_TICK),
    .RATE_IDX (RATE_IDX)
  );
  typedef struct packed {logic os; logic mid; logic baud; logic [1:0] idx;} obs_t;
  localparam longint WRAP = 64'd16777216;
  longint inc_m [4] = '{51540, 103079, 309238, 618475};
  obs_t sb[$];
  obs_t got;
  int tests = 0, fails = 0;
  longint m_acc;
  int m_os, m_rate;
  int n, n_os, n_mid, quiet;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_acc = 0;
    m_os = 0;
    m_rate = 0;
  endtask
  task automatic step();
    obs_t e;
    int sel;
    sel = int'(RATE_SEL);
    e = '0;
    if (RESYNC || sel != m_rate) begin
      m_acc = 0;
      m_os = 0;
    end else if (ENABLE) begin
      m_acc += inc_m[m_rate];
      if (m_acc >= WRAP) begin
        m_acc -= WRAP;
        m_os = (m_os + 1) % 16;
        e.os = 1'b1;
        e.mid = (m_os == 8);
        e.baud = (m_os == 0);
      end
    end
    m_rate = sel;
    e.idx = 2'(sel);
    sb.push_back(e);
    @(posedge clk_50);
    #1;
    got = {OS_TICK, MID_TICK, BAUD_TICK, RATE_IDX};
    e = sb.pop_front();
    check("cycle", 32'(got), 32'(e));
  endtask
  task automatic run_until(input int which, input int limit, output int cnt, output int os_seen, output int mid_seen);
    logic hit;
    cnt = 0;
    os_seen = 0;
    mid_seen = 0;
    hit = 1'b0;
    while (!hit && cnt < limit) begin
      step();
      cnt++;
      os_seen += int'(got.os);
      mid_seen += int'(got.mid);
      hit = which == 0 ? got.os : which == 1 ? got.mid : got.baud;
    end
    check("wait_bound", 32'(hit), 32'd1);
  endtask
  initial begin
    RESET = 1'b1;
    ENABLE = 1'b1;
    RESYNC = 1'b0;
    RATE_SEL = 2'd0;
    model_reset();
    repeat (2) @(posedge clk_50);
    #1;
    check("reset_state", 32'({OS_TICK, MID_TICK, BAUD_TICK, RATE_IDX}), 32'd0);
    RESET = 1'b0;
    run_until(0, 400, n, n_os, n_mid);
    check("t1_first_os", 32'(n), 32'd326);
    check("t1_os_once", 32'(n_os), 32'd1);
    run_until(2, 6000, n, n_os, n_mid);
    for (int b = 0; b < 3; b++) begin
      run_until(2, 6000, n, n_os, n_mid);
      check("t2_span_5208_or_5209", 32'(n == 5208 || n == 5209), 32'd1);
      check("t2_os_per_bit", 32'(n_os), 32'd16);
      check("t2_mid_per_bit", 32'(n_mid), 32'd1);
    end
    repeat (2000) step();
    RATE_SEL = 2'd3;
    step();
    check("t3_rate_idx", 32'(RATE_IDX), 32'd3);
    check("t3_no_tick", 32'({OS_TICK, MID_TICK, BAUD_TICK}), 32'd0);
    run_until(0, 100, n, n_os, n_mid);
    check("t3_first_os", 32'(n), 32'd28);
    run_until(1, 2000, n, n_os, n_mid);
    check("t3_os_to_mid", 32'(n_os + 1), 32'd8);
    repeat (150) step();
    for (int k = 0; k < 100 && m_acc + inc_m[m_rate] < WRAP; k++) step();
    check("t4_carry_pending", 32'(m_acc + inc_m[m_rate] >= WRAP), 32'd1);
    RESYNC = 1'b1;
    step();
    RESYNC = 1'b0;
    check("t4_no_os", 32'(OS_TICK), 32'd0);
    check("t4_os_cnt", 32'(dut.os_cnt), 32'd0);
    run_until(1, 2000, n, n_os, n_mid);
    check("t4_os_to_mid", 32'(n_os), 32'd8);
    run_until(2, 2000, n, n_os, n_mid);
    check("t4_mid_to_baud", 32'(n_os), 32'd8);
    repeat (200) step();
    ENABLE = 1'b0;
    quiet = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      quiet += int'(got.os | got.mid | got.baud);
    end
    check("t5_gap_ticks", 32'(quiet), 32'd0);
    check("t5_acc_hold", 32'(dut.u_phase_acc.acc), 32'(m_acc));
    check("t5_os_cnt_hold", 32'(dut.os_cnt), 32'(m_os));
    ENABLE = 1'b1;
    repeat (1000) step();
    run_until(0, 100, n, n_os, n_mid);
    check("t6_pre_os", 32'(OS_TICK), 32'd1);
    #3;
    RESET = 1'b1;
    #1;
    check("t6_async_clear", 32'({OS_TICK, MID_TICK, BAUD_TICK, RATE_IDX}), 32'd0);
    RATE_SEL = 2'd0;
    repeat (3) @(posedge clk_50);
    #1;
    RESET = 1'b0;
    model_reset();
    run_until(0, 400, n, n_os, n_mid);
    check("t6_first_os", 32'(n), 32'd326);
    check("t6_os_once", 32'(n_os), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
